// File: rtl/mem_arbiter.sv
// Shares one single-ported sync RAM between instruction fetch and load/store data paths.
// Latency: grants are combinational; read data returns exactly one cycle after the grant.
// Backpressure: a requester holds req/inputs until its gnt; ungranted requesters simply wait.
module mem_arbiter #(
  parameter int n    = 32,
  parameter int alen = 6
) (
  input  logic            clock,
  input  logic            reset,
  // instruction fetch requester
  input  logic            if_req,
  input  logic [alen-1:0] if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [n-1:0]    if_rdata,
  // load/store requester
  input  logic            d_req,
  input  logic            d_we,
  input  logic [alen-1:0] d_addr,
  input  logic [n-1:0]    d_wdata,
  input  logic [n/8-1:0]  d_be,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [n-1:0]    d_rdata,
  // RAM port
  output logic            m_en,
  output logic            m_we,
  output logic [alen-1:0] m_addr,
  output logic [n-1:0]    m_wdata,
  output logic [n/8-1:0]  m_be,
  input  logic [n-1:0]    m_rdata
);

  localparam int nb = n / 8;

  // Which requester owns the read data coming back from the RAM this cycle.
  typedef enum logic [1:0] {
    RESP_NONE  = 2'b00,
    RESP_FETCH = 2'b01,
    RESP_DATA  = 2'b10
  } resp_t;

  // prio = 0: data wins a conflict; prio = 1: fetch wins a conflict.
  logic  prio;
  resp_t resp_sel;

  // Exactly one grant per cycle; the loser of a conflict wins the next one.
  assign d_gnt  = d_req & (~if_req | ~prio);
  assign if_gnt = if_req & ~d_gnt;

  // Steer the granted request onto the RAM port; park the port at zero when idle.
  always_comb begin
    m_en    = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_be    = '0;
    if (d_gnt) begin
      m_en    = 1'b1;
      m_we    = d_we;
      m_addr  = d_addr;
      m_wdata = d_wdata;
      m_be    = d_be;
    end else if (if_gnt) begin
      m_en    = 1'b1;
      m_addr  = if_addr;
      m_be    = {nb{1'b1}};
    end
  end

  // Update conflict priority and remember who gets next cycle's read data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prio     <= 1'b0;
      resp_sel <= RESP_NONE;
    end else begin
      if (d_gnt && if_req) begin
        prio <= 1'b1;
      end else if (if_gnt) begin
        prio <= 1'b0;
      end
      if (if_gnt) begin
        resp_sel <= RESP_FETCH;
      end else if (d_gnt && !d_we) begin
        resp_sel <= RESP_DATA;
      end else begin
        resp_sel <= RESP_NONE;
      end
    end
  end

  // Route RAM read data to its owner; the other side sees zero.
  assign if_rvalid = (resp_sel == RESP_FETCH);
  assign d_rvalid  = (resp_sel == RESP_DATA);
  assign if_rdata  = if_rvalid ? m_rdata : '0;
  assign d_rdata   = d_rvalid  ? m_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed requests against a behavioural RAM, responses scoreboarded.
module tb_mem_arbiter;

  logic        clock;
  logic        reset;
  logic        if_req;
  logic [5:0]  if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [5:0]  d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        m_en;
  logic        m_we;
  logic [5:0]  m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic [31:0] m_rdata;

  mem_arbiter #(.n(32), .alen(6)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_rdata(m_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t if_q[$];
  exp_t d_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural single-port RAM with byte enables and one-cycle read latency.
  logic [31:0] ram [0:63];
  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 32'h0;
    ram[2]  = 32'h12345678;
    ram[4]  = 32'h00500093;
    ram[5]  = 32'h00A00113;
    ram[16] = 32'hCAFEF00D;
    for (int a = 20; a < 27; a++) ram[a] = 32'hA0000000 | a;
    m_rdata = 32'h0;
  end

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (m_en) begin
      if (m_we) begin
        for (int b = 0; b < 4; b++)
          if (m_be[b]) ram[m_addr][8*b +: 8] <= m_wdata[8*b +: 8];
      end else begin
        m_rdata <= ram[m_addr];
      end
    end
  end

  // Monitor: pops expected read data whenever a response is presented.
  always @(negedge clock) begin
    exp_t e;
    if (if_rvalid) begin
      if (if_q.size() == 0) begin
        check("if_rvalid_unexpected", 64'(if_rdata), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = if_q.pop_front();
        check("if_rdata", 64'(if_rdata), 64'(e.data));
        check("if_latency", 64'(cyc), 64'(e.due));
      end
    end else begin
      check("if_rdata_idle", 64'(if_rdata), 64'h0);
    end
    if (d_rvalid) begin
      if (d_q.size() == 0) begin
        check("d_rvalid_unexpected", 64'(d_rdata), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = d_q.pop_front();
        check("d_rdata", 64'(d_rdata), 64'(e.data));
        check("d_latency", 64'(cyc), 64'(e.due));
      end
    end else begin
      check("d_rdata_idle", 64'(d_rdata), 64'h0);
    end
  end

  // One request cycle: drive, check grant and RAM port, queue the expected response.
  task automatic step(input logic ir, input logic [5:0] ia,
                      input logic dr, input logic dwe, input logic [5:0] da,
                      input logic [31:0] dwd, input logic [3:0] dbe,
                      input logic eig, input logic edg, input logic [31:0] edat,
                      input string tag);
    exp_t e;
    if_req = ir; if_addr = ia;
    d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd; d_be = dbe;
    #2;
    check({tag, "_if_gnt"}, 64'(if_gnt), 64'(eig));
    check({tag, "_d_gnt"}, 64'(d_gnt), 64'(edg));
    check({tag, "_m_en"}, 64'(m_en), 64'(eig | edg));
    if (edg) begin
      check({tag, "_m_addr"}, 64'(m_addr), 64'(da));
      check({tag, "_m_we"}, 64'(m_we), 64'(dwe));
      check({tag, "_m_be"}, 64'(m_be), 64'(dbe));
      if (dwe) check({tag, "_m_wdata"}, 64'(m_wdata), 64'(dwd));
      else begin
        e.data = edat; e.due = cyc + 1; d_q.push_back(e);
      end
    end else if (eig) begin
      check({tag, "_m_addr"}, 64'(m_addr), 64'(ia));
      check({tag, "_m_we"}, 64'(m_we), 64'h0);
      check({tag, "_m_be"}, 64'(m_be), 64'hF);
      e.data = edat; e.due = cyc + 1; if_q.push_back(e);
    end else begin
      check({tag, "_m_addr"}, 64'(m_addr), 64'h0);
      check({tag, "_m_be"}, 64'(m_be), 64'h0);
    end
    @(posedge clock); #1;
  endtask

  task automatic idle(input string tag);
    step(1'b0, 6'h0, 1'b0, 1'b0, 6'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, tag);
  endtask

  initial begin
    reset = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
    #2;
    check("rst_if_rvalid", 64'(if_rvalid), 64'h0);
    check("rst_d_rvalid", 64'(d_rvalid), 64'h0);
    check("rst_m_en", 64'(m_en), 64'h0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;

    // single fetch
    step(1'b1, 6'h04, 1'b0, 1'b0, 6'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h00500093, "t1");
    idle("t1_idle");

    // conflicting load and fetch at prio 0
    step(1'b1, 6'h05, 1'b1, 1'b0, 6'h10, 32'h0, 4'h0, 1'b0, 1'b1, 32'hCAFEF00D, "t2a");
    step(1'b1, 6'h05, 1'b0, 1'b0, 6'h00, 32'h0, 4'h0, 1'b1, 1'b0, 32'h00A00113, "t2b");
    idle("t2_idle");

    // partial store then load back
    step(1'b0, 6'h0, 1'b1, 1'b1, 6'h08, 32'hDEADBEEF, 4'b0011, 1'b0, 1'b1, 32'h0, "t3s");
    step(1'b0, 6'h0, 1'b1, 1'b0, 6'h08, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0000BEEF, "t3l");
    idle("t3_idle");

    // both held for six cycles: D F D F D F
    step(1'b1, 6'd21, 1'b1, 1'b0, 6'd20, 32'h0, 4'h0, 1'b0, 1'b1, 32'hA0000014, "t4a");
    step(1'b1, 6'd21, 1'b1, 1'b0, 6'd22, 32'h0, 4'h0, 1'b1, 1'b0, 32'hA0000015, "t4b");
    step(1'b1, 6'd23, 1'b1, 1'b0, 6'd22, 32'h0, 4'h0, 1'b0, 1'b1, 32'hA0000016, "t4c");
    step(1'b1, 6'd23, 1'b1, 1'b0, 6'd24, 32'h0, 4'h0, 1'b1, 1'b0, 32'hA0000017, "t4d");
    step(1'b1, 6'd25, 1'b1, 1'b0, 6'd24, 32'h0, 4'h0, 1'b0, 1'b1, 32'hA0000018, "t4e");
    step(1'b1, 6'd25, 1'b1, 1'b0, 6'd26, 32'h0, 4'h0, 1'b1, 1'b0, 32'hA0000019, "t4f");
    idle("t4_idle");

    // store with no byte enables leaves memory untouched
    step(1'b0, 6'h0, 1'b1, 1'b1, 6'h02, 32'hFFFFFFFF, 4'h0, 1'b0, 1'b1, 32'h0, "t6s");
    step(1'b0, 6'h0, 1'b1, 1'b0, 6'h02, 32'h0, 4'h0, 1'b0, 1'b1, 32'h12345678, "t6l");
    idle("t6_idle");

    // fetch granted, then reset before the edge drops the response
    if_req = 1'b1; if_addr = 6'h04;
    #2;
    check("t5_if_gnt", 64'(if_gnt), 64'h1);
    reset = 1'b0;
    #1;
    if_req = 1'b0;
    check("t5_rst_if_rvalid", 64'(if_rvalid), 64'h0);
    @(posedge clock); #1;
    check("t5_post_if_rvalid", 64'(if_rvalid), 64'h0);
    check("t5_post_d_rvalid", 64'(d_rvalid), 64'h0);
    @(posedge clock); #1;
    reset = 1'b1;
    idle("t5_idle0");
    idle("t5_idle1");
    // priority returned to data-first after reset
    step(1'b1, 6'h05, 1'b1, 1'b0, 6'h10, 32'h0, 4'h0, 1'b0, 1'b1, 32'hCAFEF00D, "t5p");
    step(1'b1, 6'h05, 1'b0, 1'b0, 6'h00, 32'h0, 4'h0, 1'b1, 1'b0, 32'h00A00113, "t5f");
    idle("end_idle0");
    idle("end_idle1");

    check("if_q_drained", 64'(if_q.size()), 64'h0);
    check("d_q_drained", 64'(d_q.size()), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
